// File: rtl/rom_arbiter.sv
// Single-port ROM scheduler: download writes take priority over round-robin
// CPU / sound CPU reads. Every output is registered.
module rom_arbiter #(
  parameter int          AW       = 16,
  parameter int          RD_LAT   = 1,
  parameter logic [1:0]  SND_BASE = 2'b11
) (
  input  logic          clock_40,
  input  logic          reset,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [16:0]   dl_addr,
  input  logic [7:0]    dl_data,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_ack,
  output logic [7:0]    cpu_do,
  input  logic          snd_req,
  input  logic [13:0]   snd_addr,
  output logic          snd_ack,
  output logic [7:0]    snd_do,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_d,
  input  logic [7:0]    mem_q,
  output logic          dl_ovf,
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD_CPU = 2'd1, RD_SND = 2'd2, WR = 2'd3} state_t;

  state_t          state, state_d;
  logic [2:0]      cnt, cnt_d;
  logic            buf_valid, buf_valid_d;
  logic [15:0]     buf_addr, buf_addr_d;
  logic [7:0]      buf_data, buf_data_d;
  logic            last_snd, last_snd_d;
  logic            cpu_ack_d, snd_ack_d, mem_we_d, dl_ovf_d;
  logic [7:0]      cpu_do_d, snd_do_d, mem_d_d;
  logic [AW-1:0]   mem_addr_d;

  // Handshake: req is a level held (with a stable address) until the one-cycle
  // ack; a req still high in its ack cycle is masked so it cannot re-grant.
  logic wr_in, cpu_elig, snd_elig, pick_cpu, pick_snd, rd_done;
  assign wr_in    = dl_wr & ~dl_addr[16];
  assign cpu_elig = cpu_req & ~cpu_ack;
  assign snd_elig = snd_req & ~snd_ack;
  assign pick_cpu = cpu_elig & (~snd_elig | last_snd);
  assign pick_snd = snd_elig & ~pick_cpu;
  assign rd_done  = (cnt == 3'd0);
  assign fsm_state = state;

  always_ff @(posedge clock_40) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      buf_valid <= 1'b0;
      buf_addr  <= 16'd0;
      buf_data  <= 8'd0;
      last_snd  <= 1'b1;
      cpu_ack   <= 1'b0;
      snd_ack   <= 1'b0;
      cpu_do    <= 8'd0;
      snd_do    <= 8'd0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_d     <= 8'd0;
      dl_ovf    <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      buf_valid <= buf_valid_d;
      buf_addr  <= buf_addr_d;
      buf_data  <= buf_data_d;
      last_snd  <= last_snd_d;
      cpu_ack   <= cpu_ack_d;
      snd_ack   <= snd_ack_d;
      cpu_do    <= cpu_do_d;
      snd_do    <= snd_do_d;
      mem_addr  <= mem_addr_d;
      mem_we    <= mem_we_d;
      mem_d     <= mem_d_d;
      dl_ovf    <= dl_ovf_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (buf_valid || wr_in)           state_d = WR;
        else if (!dl_active && pick_cpu)  state_d = RD_CPU;
        else if (!dl_active && pick_snd)  state_d = RD_SND;
      end
      RD_CPU, RD_SND: if (rd_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt;
    last_snd_d  = last_snd;
    cpu_ack_d   = 1'b0;
    snd_ack_d   = 1'b0;
    cpu_do_d    = cpu_do;
    snd_do_d    = snd_do;
    mem_addr_d  = mem_addr;
    mem_we_d    = 1'b0;
    mem_d_d     = mem_d;
    buf_valid_d = buf_valid;
    buf_addr_d  = buf_addr;
    buf_data_d  = buf_data;
    dl_ovf_d    = dl_ovf;
    case (state)
      IDLE: begin
        if (buf_valid) begin
          mem_addr_d  = AW'(buf_addr);
          mem_d_d     = buf_data;
          mem_we_d    = 1'b1;
          buf_valid_d = 1'b0;
        end else if (wr_in) begin
          mem_addr_d = AW'(dl_addr[15:0]);
          mem_d_d    = dl_data;
          mem_we_d   = 1'b1;
        end else if (state_d == RD_CPU) begin
          mem_addr_d = cpu_addr;
          cnt_d      = 3'(RD_LAT);
        end else if (state_d == RD_SND) begin
          mem_addr_d = AW'({SND_BASE, snd_addr});
          cnt_d      = 3'(RD_LAT);
        end
      end
      RD_CPU: begin
        if (rd_done) begin
          cpu_do_d   = mem_q;
          cpu_ack_d  = 1'b1;
          last_snd_d = 1'b0;
        end else cnt_d = cnt - 3'd1;
      end
      RD_SND: begin
        if (rd_done) begin
          snd_do_d   = mem_q;
          snd_ack_d  = 1'b1;
          last_snd_d = 1'b1;
        end else cnt_d = cnt - 3'd1;
      end
      default: ;
    endcase
    // Bytes not taken straight from IDLE park in the single-entry buffer;
    // a byte arriving while it is occupied is lost and flagged.
    if (wr_in) begin
      if (buf_valid) dl_ovf_d = 1'b1;
      else if (state != IDLE) begin
        buf_valid_d = 1'b1;
        buf_addr_d  = dl_addr[15:0];
        buf_data_d  = dl_data;
      end
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: reads, round-robin, download writes,
// write-buffer overflow, out-of-range drop and mid-read reset.
module tb_rom_arbiter;

  logic        clock_40 = 1'b0;
  logic        reset = 1'b1;
  logic        dl_active = 1'b0, dl_wr = 1'b0;
  logic [16:0] dl_addr = '0;
  logic [7:0]  dl_data = '0;
  logic        cpu_req = 1'b0, snd_req = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [13:0] snd_addr = '0;
  logic        cpu_ack, snd_ack, mem_we, dl_ovf;
  logic [7:0]  cpu_do, snd_do, mem_d;
  logic [7:0]  mem_q = '0;
  logic [15:0] mem_addr;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  int we_count = 0;
  int cpu_acks = 0;
  int snd_acks = 0;
  logic [23:0] exp_q[$];

  always #5 clock_40 = ~clock_40;

  rom_arbiter #(.AW(16), .RD_LAT(1), .SND_BASE(2'b11)) dut (
    .clock_40(clock_40), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ack(cpu_ack), .cpu_do(cpu_do), .snd_req(snd_req), .snd_addr(snd_addr),
    .snd_ack(snd_ack), .snd_do(snd_do), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_d(mem_d), .mem_q(mem_q), .dl_ovf(dl_ovf), .fsm_state(fsm_state)
  );

  function automatic logic [7:0] rom_fn(input logic [15:0] a);
    if (a == 16'h1234) return 8'hA5;
    return a[7:0] ^ 8'h5A;
  endfunction

  // One-cycle synchronous-read memory
  always @(posedge clock_40) mem_q <= rom_fn(mem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock_40) begin
    logic [23:0] e;
    if (cpu_ack === 1'b1) cpu_acks++;
    if (snd_ack === 1'b1) snd_acks++;
    if (mem_we === 1'b1) begin
      we_count++;
      check("we_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("we_addr_data", {8'h0, mem_addr, mem_d}, {8'h0, e});
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
    check({tag, "_snd_ack"}, 32'(snd_ack), 32'd0);
    check({tag, "_cpu_do"}, 32'(cpu_do), 32'd0);
    check({tag, "_snd_do"}, 32'(snd_do), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_d"}, 32'(mem_d), 32'd0);
    check({tag, "_dl_ovf"}, 32'(dl_ovf), 32'd0);
    check({tag, "_state"}, 32'(fsm_state), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock_40);
    reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    cpu_req = 1'b0; snd_req = 1'b0; cpu_addr = '0; snd_addr = '0;
    @(negedge clock_40);
    @(negedge clock_40);
    check_reset_vals(tag);
    reset = 1'b0;
  endtask

  task automatic wait_ack(input bit snd, input int limit, output int n);
    n = 0;
    forever begin
      @(negedge clock_40);
      n++;
      if ((snd ? snd_ack : cpu_ack) === 1'b1) break;
      if (n > limit) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int base_ack, base_we, n;

    // Single CPU read
    do_reset("rst1");
    base_ack = cpu_acks;
    cpu_addr = 16'h1234; cpu_req = 1'b1;
    @(negedge clock_40);
    check("t1_mem_addr", 32'(mem_addr), 32'h1234);
    check("t1_ack_k0", 32'(cpu_ack), 32'd0);
    @(negedge clock_40);
    check("t1_ack_k1", 32'(cpu_ack), 32'd0);
    @(negedge clock_40);
    check("t1_ack_k2", 32'(cpu_ack), 32'd1);
    check("t1_do", 32'(cpu_do), 32'hA5);
    cpu_req = 1'b0;
    @(negedge clock_40);
    check("t1_ack_k3", 32'(cpu_ack), 32'd0);
    check("t1_do_hold", 32'(cpu_do), 32'hA5);
    repeat (3) @(negedge clock_40);
    check("t1_ack_count", 32'(cpu_acks - base_ack), 32'd1);

    // Round-robin with both requesters busy
    do_reset("rst2");
    cpu_addr = 16'h0042; snd_addr = 14'h0010; cpu_req = 1'b1; snd_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock_40);
      check($sformatf("t2_cpu_ack_k%0d", k), 32'(cpu_ack), 32'(k == 2 || k == 8));
      check($sformatf("t2_snd_ack_k%0d", k), 32'(snd_ack), 32'(k == 5 || k == 11));
      if (k == 0) check("t2_cpu_addr", 32'(mem_addr), 32'h0042);
      if (k == 3) check("t2_snd_addr", 32'(mem_addr), 32'hC010);
      if (cpu_ack) check("t2_cpu_do", 32'(cpu_do), 32'h18);
      if (snd_ack) check("t2_snd_do", 32'(snd_do), 32'h4A);
      if (k == 11) begin cpu_req = 1'b0; snd_req = 1'b0; end
    end

    // Download writes block reads while dl_active
    do_reset("rst3");
    base_ack = cpu_acks; base_we = we_count;
    dl_active = 1'b1; cpu_addr = 16'h0042; cpu_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock_40);
      dl_wr = 1'b1; dl_addr = 17'(i); dl_data = 8'(8'h10 + i);
      exp_q.push_back({16'(i), 8'(8'h10 + i)});
      @(negedge clock_40);
      dl_wr = 1'b0;
      repeat (2) @(negedge clock_40);
    end
    check("t3_we_count", 32'(we_count - base_we), 32'd4);
    check("t3_exp_empty", 32'(exp_q.size()), 32'd0);
    check("t3_no_ack", 32'(cpu_acks - base_ack), 32'd0);
    dl_active = 1'b0;
    wait_ack(1'b0, 8, n);
    check("t3_ack_latency", 32'(n), 32'd3);
    cpu_req = 1'b0;
    repeat (3) @(negedge clock_40);
    check("t3_ack_count", 32'(cpu_acks - base_ack), 32'd1);

    // Buffered write during a read, then overflow
    do_reset("rst4");
    base_we = we_count;
    cpu_addr = 16'h0042; cpu_req = 1'b1;
    @(negedge clock_40);
    dl_wr = 1'b1; dl_addr = 17'h00005; dl_data = 8'h77;
    exp_q.push_back({16'h0005, 8'h77});
    @(negedge clock_40);
    check("t4_ovf_k1", 32'(dl_ovf), 32'd0);
    dl_addr = 17'h00006; dl_data = 8'h88;
    @(negedge clock_40);
    dl_wr = 1'b0;
    check("t4_ack", 32'(cpu_ack), 32'd1);
    check("t4_do", 32'(cpu_do), 32'h18);
    check("t4_ovf_k2", 32'(dl_ovf), 32'd1);
    check("t4_we_k2", 32'(mem_we), 32'd0);
    cpu_req = 1'b0;
    @(negedge clock_40);
    check("t4_state_wr", 32'(fsm_state), 32'd3);
    repeat (4) @(negedge clock_40);
    check("t4_ovf_sticky", 32'(dl_ovf), 32'd1);
    check("t4_exp_empty", 32'(exp_q.size()), 32'd0);
    check("t4_we_count", 32'(we_count - base_we), 32'd1);

    // Out-of-range download byte is dropped silently
    do_reset("rst5");
    base_we = we_count;
    @(negedge clock_40);
    dl_wr = 1'b1; dl_addr = 17'h10000; dl_data = 8'h99;
    @(negedge clock_40);
    dl_wr = 1'b0;
    repeat (4) @(negedge clock_40);
    check("t5_we_count", 32'(we_count - base_we), 32'd0);
    check("t5_ovf", 32'(dl_ovf), 32'd0);
    check("t5_state", 32'(fsm_state), 32'd0);

    // Reset one cycle into a sound read
    do_reset("rst6");
    base_ack = snd_acks;
    snd_addr = 14'h0010; snd_req = 1'b1;
    @(negedge clock_40);
    check("t6_state_rd", 32'(fsm_state), 32'd2);
    check("t6_mem_addr", 32'(mem_addr), 32'hC010);
    reset = 1'b1;
    @(negedge clock_40);
    check_reset_vals("t6_mid");
    reset = 1'b0;
    wait_ack(1'b1, 8, n);
    check("t6_ack_latency", 32'(n), 32'd3);
    check("t6_snd_do", 32'(snd_do), 32'h4A);
    snd_req = 1'b0;
    repeat (3) @(negedge clock_40);
    check("t6_ack_count", 32'(snd_acks - base_ack), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
